// File: rtl/copro_pkg.sv
// Shared types for the shift-add multiplier co-processor.
//   state_e   : sequencer states
//   OpLimit   : number of operands a multiply consumes (A then B)
package copro_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFix
  } state_e;

  localparam int unsigned OpLimit = 2;

endpackage

// File: rtl/copro_abs.sv
// Conditional two's-complement negate, purely combinational.
//   val : input value
//   neg : 1 = output -val, 0 = pass val through
//   res : result, same width as val
// Used to take operand magnitudes and to re-apply the product sign.
// The most negative value maps onto itself, which read as unsigned is its magnitude.
module copro_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  always_comb begin
    res = neg ? (~val + 1'b1) : val;
  end

endmodule

// File: rtl/copro_mul_p.sv
// Iterative radix-2 shift-add multiplier co-processor.
//   ck, rb : clock (rising edge) and asynchronous active-low reset
//   start  : begin a multiply on the two pushed operands
//   sgn    : sampled with start, 1 = two's-complement operands
//   dpsh   : push dinp into the operand pair (A first, then B)
//   dinp   : operand data
//   dpop   : swap the product high/low registers
//   ready  : one-cycle pulse when the product is available
//   busy   : multiply in progress
//   err    : one-cycle pulse when start is rejected (too few operands)
//   dout   : current head of the product registers
module copro_mul_p
  import copro_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         ck,
  input  logic         rb,
  input  logic         start,
  input  logic         sgn,
  input  logic         dpsh,
  input  logic [W-1:0] dinp,
  input  logic         dpop,
  output logic         ready,
  output logic         busy,
  output logic         err,
  output logic [W-1:0] dout
);

  localparam int unsigned CW = $clog2(W);

  state_e          state;
  logic [W-1:0]    areg, breg, mh, ml;
  logic [CW-1:0]   cnt;
  logic [1:0]      opcnt;
  logic            neg;
  logic            mode;   // sgn captured at start

  logic [W-1:0]    a_abs, b_abs;
  logic [2*W-1:0]  prod_fix;
  logic [2*W-1:0]  sum;

  copro_abs #(.W(W)) u_abs_a (
    .val (areg),
    .neg (mode & areg[W-1]),
    .res (a_abs)
  );

  copro_abs #(.W(W)) u_abs_b (
    .val (breg),
    .neg (mode & breg[W-1]),
    .res (b_abs)
  );

  copro_abs #(.W(2*W)) u_abs_p (
    .val ({mh, ml}),
    .neg (neg),
    .res (prod_fix)
  );

  // Shift the partial product right by one and add B aligned at bit W-1.
  // The partial product never reaches 2^(2W), so no carry out is lost.
  always_comb begin
    sum = {1'b0, mh, ml[W-1:1]}
        + (areg[0] ? {1'b0, breg, {(W-1){1'b0}}} : {(2*W){1'b0}});
  end

  assign dout = mh;

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      state <= StIdle;
      areg  <= '0;
      breg  <= '0;
      mh    <= '0;
      ml    <= '0;
      cnt   <= '0;
      opcnt <= '0;
      neg   <= 1'b0;
      mode  <= 1'b0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        StIdle: begin
          // start takes priority: a same-cycle push or pop is dropped
          if (start) begin
            if (opcnt == 2'(OpLimit)) begin
              state <= StLoad;
              busy  <= 1'b1;
              mode  <= sgn;
            end else begin
              err <= 1'b1;
            end
          end else begin
            if (dpsh) begin
              areg <= breg;
              breg <= dinp;
              if (opcnt != 2'(OpLimit)) opcnt <= opcnt + 2'd1;
            end
            if (dpop) begin
              mh <= ml;
              ml <= mh;
            end
          end
        end
        StLoad: begin
          mh    <= '0;
          ml    <= '0;
          areg  <= a_abs;
          breg  <= b_abs;
          neg   <= mode & (areg[W-1] ^ breg[W-1]);
          cnt   <= '0;
          opcnt <= '0;
          state <= StRun;
        end
        StRun: begin
          {mh, ml} <= sum;
          areg     <= areg >> 1;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= StFix;
        end
        StFix: begin
          {mh, ml} <= prod_fix;
          state    <= StIdle;
          busy     <= 1'b0;
          ready    <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_copro_mul_p.sv
// Self-checking bench: a W=32 and a W=8 instance share every control input, so
// each operation is checked at both widths against arithmetic reference models.
module tb_copro_mul_p;

  logic        ck = 1'b0;
  logic        rb, start, sgn, dpsh, dpop;
  logic [31:0] dinp;
  logic [7:0]  dinp8;
  logic        ready32, busy32, err32;
  logic [31:0] dout32;
  logic        ready8, busy8, err8;
  logic [7:0]  dout8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ck = ~ck;

  copro_mul_p #(.W(32)) u_dut32 (
    .ck(ck), .rb(rb), .start(start), .sgn(sgn), .dpsh(dpsh), .dinp(dinp),
    .dpop(dpop), .ready(ready32), .busy(busy32), .err(err32), .dout(dout32)
  );

  copro_mul_p #(.W(8)) u_dut8 (
    .ck(ck), .rb(rb), .start(start), .sgn(sgn), .dpsh(dpsh), .dinp(dinp8),
    .dpop(dpop), .ready(ready8), .busy(busy8), .err(err8), .dout(dout8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] e32;
    logic [15:0] e8;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    if (s) return longint'($signed(a)) * longint'($signed(b));
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'({24'd0, a}) * int'({24'd0, b});
    return p[15:0];
  endfunction

  task automatic push(input logic [31:0] v);
    dpsh = 1'b1; dinp = v; dinp8 = v[7:0];
    @(negedge ck);
    dpsh = 1'b0;
  endtask

  // Returns just after the edge that samples start.
  task automatic start_cmd(input logic s, input logic exp_err, input string tag);
    start = 1'b1; sgn = s;
    @(negedge ck);
    start = 1'b0;
    check({tag, ".err32"}, err32, exp_err);
    check({tag, ".err8"}, err8, exp_err);
    check({tag, ".busy32"}, busy32, !exp_err);
    check({tag, ".busy8"}, busy8, !exp_err);
  endtask

  // Counts edges after start until ready; optionally throws junk commands
  // at both instances while they are still busy.
  task automatic wait_done(input logic junk, input string tag);
    int n = 0;
    int n8 = -1;
    bit done = 0;
    bit drop = 0;
    while (n < 60 && !done) begin
      if (junk && n < 9) begin
        start = 1'($urandom_range(0, 1));
        dpsh  = 1'($urandom_range(0, 1));
        dpop  = 1'($urandom_range(0, 1));
        sgn   = 1'($urandom_range(0, 1));
        dinp  = $urandom;
        dinp8 = 8'($urandom);
      end
      @(negedge ck);
      start = 1'b0; dpsh = 1'b0; dpop = 1'b0;
      n++;
      if (ready8 && n8 < 0) n8 = n;
      if (ready32) done = 1;
      else if (!busy32) drop = 1;
    end
    check({tag, ".lat32"}, 64'(n), 64'd34);
    check({tag, ".lat8"}, 64'(n8), 64'd10);
    check({tag, ".busy_drop"}, drop, 1'b0);
    check({tag, ".busy_end"}, busy32, 1'b0);
  endtask

  task automatic read_result(input logic [63:0] e32, input logic [15:0] e8, input string tag);
    check({tag, ".hi32"}, dout32, e32[63:32]);
    check({tag, ".hi8"}, dout8, e8[15:8]);
    dpop = 1'b1;
    @(negedge ck);
    dpop = 1'b0;
    check({tag, ".ready_pulse"}, ready32, 1'b0);
    check({tag, ".lo32"}, dout32, e32[31:0]);
    check({tag, ".lo8"}, dout8, e8[7:0]);
    dpop = 1'b1;
    @(negedge ck);
    dpop = 1'b0;
    check({tag, ".hi32b"}, dout32, e32[63:32]);
    check({tag, ".hi8b"}, dout8, e8[15:8]);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] e32, input logic [15:0] e8,
                        input logic junk, input string tag);
    push(a);
    push(b);
    start_cmd(s, 1'b0, tag);
    wait_done(junk, tag);
    read_result(e32, e8, tag);
  endtask

  vec_t tbl[8];

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          bad_cnt;

    tbl[0] = '{32'h3,        32'h5,        1'b0, 64'h0000000F,          16'h000F};
    tbl[1] = '{32'hFFFFFFFD, 32'h5,        1'b1, 64'hFFFFFFFF_FFFFFFF1, 16'hFFF1};
    tbl[2] = '{32'hFFFFFFFD, 32'h5,        1'b0, 64'h00000004_FFFFFFF1, 16'h04F1};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 16'hFE01};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 16'h0001};
    tbl[5] = '{32'h80,       32'h80,       1'b1, 64'h00004000,          16'h4000};
    tbl[6] = '{32'h80,       32'h7F,       1'b1, 64'h00003F80,          16'hC080};
    tbl[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000, 16'h0000};

    rb = 1'b0; start = 1'b0; sgn = 1'b0; dpsh = 1'b0; dpop = 1'b0;
    dinp = '0; dinp8 = '0;
    #12;
    check("rst.busy", busy32, 1'b0);
    check("rst.ready", ready32, 1'b0);
    check("rst.err", err32, 1'b0);
    check("rst.dout32", dout32, 32'h0);
    check("rst.dout8", dout8, 8'h0);
    @(negedge ck);
    rb = 1'b1;
    @(negedge ck);

    // One operand only: start rejected, then a normal completion.
    push(32'd7);
    start_cmd(1'b0, 1'b1, "short");
    bad_cnt = 0;
    repeat (3) begin
      @(negedge ck);
      if (err32 || busy32 || ready32 || err8 || busy8 || ready8) bad_cnt++;
    end
    check("short.quiet", 64'(bad_cnt), 64'd0);
    push(32'd9);
    start_cmd(1'b0, 1'b0, "short2");
    wait_done(1'b0, "short2");
    read_result(64'd63, 16'd63, "short2");

    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e32, tbl[i].e8, 1'b0,
                            $sformatf("tbl%0d", i));

    // start+dpsh with two operands: the push is dropped.
    push(32'h11); push(32'h13);
    start = 1'b1; dpsh = 1'b1; dinp = 32'hABCDEF01; dinp8 = 8'h01; sgn = 1'b0;
    @(negedge ck);
    start = 1'b0; dpsh = 1'b0;
    check("stpsh.busy", busy32, 1'b1);
    check("stpsh.err", err32, 1'b0);
    wait_done(1'b0, "stpsh");
    read_result(64'h143, 16'h0143, "stpsh");

    // start+dpsh with one operand: err, and the push is dropped.
    push(32'h25);
    start = 1'b1; dpsh = 1'b1; dinp = 32'h99; dinp8 = 8'h99; sgn = 1'b0;
    @(negedge ck);
    start = 1'b0; dpsh = 1'b0;
    check("stpsh1.err", err32, 1'b1);
    check("stpsh1.busy", busy32, 1'b0);
    push(32'h3);
    start_cmd(1'b0, 1'b0, "stpsh1b");
    wait_done(1'b0, "stpsh1b");
    read_result(64'h6F, 16'h006F, "stpsh1b");

    // dpsh+dpop together: both happen.
    dpsh = 1'b1; dpop = 1'b1; dinp = 32'hFFFFFFFE; dinp8 = 8'hFE;
    @(negedge ck);
    dpsh = 1'b0; dpop = 1'b0;
    check("pshpop.dout32", dout32, 32'h6F);
    push(32'h4);
    start_cmd(1'b1, 1'b0, "pshpop");
    wait_done(1'b0, "pshpop");
    read_result(64'hFFFFFFFF_FFFFFFF8, 16'hFFF8, "pshpop");

    // Randomised operands, with junk commands thrown in while busy.
    for (int k = 0; k < 30; k++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (k % 7 == 0) a = 32'h80000000;
      if (k % 5 == 0) b = {24'hFFFFFF, 8'($urandom)};
      run_op(a, b, s, model32(a, b, s), model8(a[7:0], b[7:0], s), 1'b1,
             $sformatf("rnd%0d", k));
    end

    // Reset in the middle of RUN.
    push(32'hDEADBEEF); push(32'h12345678);
    start_cmd(1'b0, 1'b0, "abort");
    repeat (11) @(negedge ck);
    #2 rb = 1'b0;
    #1;
    check("abort.busy32", busy32, 1'b0);
    check("abort.ready32", ready32, 1'b0);
    check("abort.err32", err32, 1'b0);
    check("abort.dout32", dout32, 32'h0);
    check("abort.dout8", dout8, 8'h0);
    @(negedge ck);
    rb = 1'b1;
    bad_cnt = 0;
    repeat (40) begin
      @(negedge ck);
      if (ready32 || busy32 || ready8) bad_cnt++;
    end
    check("abort.no_ready", 64'(bad_cnt), 64'd0);
    start_cmd(1'b0, 1'b1, "abort_post");
    check("abort.dout32_post", dout32, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/copro_mul_p.md
Name: copro_mul_p

Overview:
Parametrised iterative shift-add multiplier co-processor, radix-2, one partial product per clock.
- Operands are loaded through a two-deep push register pair; the 2W-bit product is read back through a pop-rotated high/low register pair.
- Adds over the 32-bit unsigned generation: width parameter, per-operation signed/unsigned mode, operand-count checking, busy/error flags, and defined behaviour for every command collision.
- Sits on the processor's co-processor port.

Parameters:
W, 32, operand width; product is 2W bits; legal range 4..64.
CW, $clog2(W), iteration counter width (derived, not overridden).

Ports:
ck  input  1  clock, rising edge
rb  input  1  asynchronous active-low reset
start  input  1  begin a multiply on the two pushed operands
sgn  input  1  sampled with start: 1 = two's-complement operands, 0 = unsigned
dpsh  input  1  push dinp into the operand pair
dinp  input  W  operand data
dpop  input  1  rotate the product registers (high<->low)
ready  output  1  one-cycle pulse: product available
busy  output  1  multiply in progress
err  output  1  one-cycle pulse: start rejected
dout  output  W  current head of the product registers (mh)

Behaviour:
- Reset (rb low, async): FSM=IDLE; areg, breg, mh, ml, cnt = 0; opcnt = 0; neg = 0; ready = busy = err = 0; dout = 0.
- Operand push (IDLE only): areg <= breg, breg <= dinp, opcnt <= min(opcnt+1, 2). The first push is A, the second is B. dpsh while busy is ignored, and opcnt is unchanged.
- FSM states: IDLE, LOAD, RUN, FIX.
- IDLE, start with opcnt==2 -> LOAD; busy <= 1.
- IDLE, start with opcnt<2 -> stay in IDLE; err pulses for 1 cycle; no register changes.
- LOAD (1 cycle):
  - mh, ml <= 0.
  - If sgn: neg <= a[W-1]^b[W-1], and areg/breg <= their absolute values. -2^(W-1) maps to the unsigned magnitude 2^(W-1).
  - If not sgn: neg <= 0.
  - cnt <= 0; opcnt <= 0.
- RUN (exactly W cycles):
  - sum = {mh,ml[W-1:1]} + (areg[0] ? {1'b0,breg,(W-1)'b0} : 0), computed at width 2W+1.
  - {mh,ml} <= sum; areg >>= 1; cnt++.
  - When cnt==W-1, go to FIX.
- FIX (1 cycle): if neg, {mh,ml} <= -{mh,ml} (2W-bit two's complement). Then -> IDLE; busy <= 0; ready pulses.
- Latency: start sampled at edge E0; ready is high in the cycle following edge E(W+2); busy is high from E0+ through E(W+2)-. The latency is identical in both modes.
- Result registers: mh = product[2W-1:W], ml = product[W-1:0]. dout = mh combinationally.
- Pop: dpop in IDLE swaps mh/ml. Repeated pops alternate high and low indefinitely; the contents are non-destructive. dpop while busy is ignored.
- Collisions:
  - start while busy is ignored, with no err.
  - start+dpsh in the same IDLE cycle: start evaluates the pre-push opcnt, and the push is discarded.
  - start+dpop in IDLE: start wins and the pop is discarded.
  - dpsh+dpop in IDLE: both occur.
- Reset asserted mid-operation aborts immediately to the reset state. No ready pulse is produced, and the partial product is lost.
- breg is unchanged by RUN and FIX; areg ends at 0.

Decomposition:
- Package copro_pkg holds: state enum typedef (IDLE, LOAD, RUN, FIX) and the W-independent localparam for the opcnt limit (2).
- One sub-module, copro_abs (parametrised W): combinational conditional two's-complement negate. It is used in LOAD for both operands and in FIX at width 2W.

Test Plan:
1. W=32, push 3 then 5, start with sgn=0 -> ready at E34; dout=0x00000000; after one dpop, dout=0x0000000F; after a second dpop, dout=0x00000000.
2. W=32, push 0xFFFFFFFD (-3) then 5, start with sgn=1 -> high=0xFFFFFFFF, low=0xFFFFFFF1. The same operands with sgn=0 -> high=0x00000004, low=0xFFFFFFF1.
3. W=32, push 0xFFFFFFFF twice, sgn=0 -> product 0xFFFFFFFE_00000001. The same operands with sgn=1 -> 0x00000000_00000001.
4. W=8, push 0x80 twice, sgn=1 -> product 0x4000. Push 0x80 then 0x7F, sgn=1 -> 0xC080.
5. Reset, push one operand, start -> err=1 for one cycle, busy stays 0, no ready. Push again and start -> normal completion. During busy, start/dpsh/dpop are ignored, and the result matches a collision-free run.
6. Drop rb at cycle 10 of RUN -> all outputs 0 asynchronously, no ready. After release, opcnt=0, and start produces an err pulse.
